// File: rtl/age_ordered_issue_select_pkg.sv
// age_ordered_issue_select_pkg: shared defaults, select-mode enum and index-width helper for the issue queue
package age_ordered_issue_select_pkg;
    localparam int QUEUE_DEPTH_DEF = 8;
    localparam int ISSUE_WIDTH_DEF = 2;
    typedef enum logic {SEL_LOWEST_INDEX, SEL_OLDEST_FIRST} sel_mode_e;
    function automatic int idx_w(input int depth);
        return $clog2(depth);
    endfunction
endpackage

// File: rtl/age_ordered_issue_select_if.sv
// age_ordered_issue_select_if: dispatch/wakeup/issue-port bundle between rename and the issue queue
interface age_ordered_issue_select_if
    import age_ordered_issue_select_pkg::*;
#(
    parameter int QUEUE_DEPTH = QUEUE_DEPTH_DEF,
    parameter int ISSUE_WIDTH = ISSUE_WIDTH_DEF
);
    localparam int IW = idx_w(QUEUE_DEPTH);
    logic alloc_req;
    logic alloc_ack;
    logic [IW-1:0] alloc_idx;
    logic full;
    logic [IW:0] free_count;
    logic [QUEUE_DEPTH-1:0] occupied;
    logic [QUEUE_DEPTH-1:0] slot_ready;
    logic [ISSUE_WIDTH-1:0] issue_valid;
    logic [ISSUE_WIDTH*IW-1:0] issue_idx;
    logic [ISSUE_WIDTH-1:0] issue_ack;
    logic flush;
    modport master (
        output alloc_req, slot_ready, issue_ack, flush,
        input alloc_ack, alloc_idx, full, free_count, occupied, issue_valid, issue_idx
    );
    modport slave (
        input alloc_req, slot_ready, issue_ack, flush,
        output alloc_ack, alloc_idx, full, free_count, occupied, issue_valid, issue_idx
    );
endinterface

// File: rtl/age_ordered_issue_select_age_matrix.sv
// age_ordered_issue_select_age_matrix: older[i][j] age state plus successive oldest-among-candidate picks
module age_ordered_issue_select_age_matrix
    import age_ordered_issue_select_pkg::*;
#(
    parameter int QUEUE_DEPTH = QUEUE_DEPTH_DEF,
    parameter int ISSUE_WIDTH = ISSUE_WIDTH_DEF
) (
    input  logic clk,
    input  logic rst,
    input  logic alloc_en,
    input  logic [idx_w(QUEUE_DEPTH)-1:0] alloc_idx,
    input  logic [QUEUE_DEPTH-1:0] cand,
    output logic [ISSUE_WIDTH-1:0][QUEUE_DEPTH-1:0] oldest
);
    localparam logic [QUEUE_DEPTH-1:0] ONE = 1;
    logic [QUEUE_DEPTH-1:0] older [QUEUE_DEPTH];
    logic [QUEUE_DEPTH-1:0] col [QUEUE_DEPTH];
    logic [QUEUE_DEPTH-1:0] mask;
    // new entry is younger than everyone: its row clears, its column sets
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < QUEUE_DEPTH; i++) older[i] <= '0;
        end else if (alloc_en) begin
            for (int i = 0; i < QUEUE_DEPTH; i++)
                older[i] <= (i == int'(alloc_idx)) ? '0 : (older[i] | (ONE << alloc_idx));
        end
    end
    always_comb begin
        for (int i = 0; i < QUEUE_DEPTH; i++)
            for (int j = 0; j < QUEUE_DEPTH; j++)
                col[i][j] = older[j][i];
    end
    // a slot is oldest when no remaining candidate is older than it
    always_comb begin
        mask = cand;
        oldest = '0;
        for (int k = 0; k < ISSUE_WIDTH; k++) begin
            for (int i = 0; i < QUEUE_DEPTH; i++)
                oldest[k][i] = mask[i] && ((col[i] & mask) == '0);
            mask = mask & ~oldest[k];
        end
    end
endmodule

// File: rtl/age_ordered_issue_select.sv
// age_ordered_issue_select: issue-queue occupancy tracker with allocate, multi-port select and ack-free
module age_ordered_issue_select
    import age_ordered_issue_select_pkg::*;
#(
    parameter int QUEUE_DEPTH = QUEUE_DEPTH_DEF,
    parameter int ISSUE_WIDTH = ISSUE_WIDTH_DEF,
    parameter int AGE_ORDER = 1
) (
    input logic clk,
    input logic rst,
    age_ordered_issue_select_if.slave bus
);
    localparam int IW = idx_w(QUEUE_DEPTH);
    localparam sel_mode_e MODE = sel_mode_e'(AGE_ORDER != 0);
    localparam logic [QUEUE_DEPTH-1:0] ONE = 1;
    logic [QUEUE_DEPTH-1:0] occ;
    logic [QUEUE_DEPTH-1:0] cand;
    logic [QUEUE_DEPTH-1:0] freed;
    logic [ISSUE_WIDTH-1:0][QUEUE_DEPTH-1:0] sel;
    logic [IW:0] cnt;
    logic [IW-1:0] free_idx;
    assign cand = occ & bus.slot_ready;
    always_comb begin
        cnt = '0;
        free_idx = '0;
        for (int i = QUEUE_DEPTH - 1; i >= 0; i--) begin
            cnt = cnt + {{IW{1'b0}}, ~occ[i]};
            free_idx = occ[i] ? free_idx : IW'(i);
        end
    end
    assign bus.occupied = occ;
    assign bus.free_count = cnt;
    assign bus.full = (cnt == '0);
    assign bus.alloc_idx = free_idx;
    // reset and flush both veto allocation so no slot is claimed into cleared state
    assign bus.alloc_ack = bus.alloc_req && !bus.full && !bus.flush && !rst;
    if (MODE == SEL_OLDEST_FIRST) begin : g_age
        age_ordered_issue_select_age_matrix #(
            .QUEUE_DEPTH(QUEUE_DEPTH),
            .ISSUE_WIDTH(ISSUE_WIDTH)
        ) u_age (
            .clk(clk),
            .rst(rst),
            .alloc_en(bus.alloc_ack),
            .alloc_idx(free_idx),
            .cand(cand),
            .oldest(sel)
        );
    end else begin : g_low
        logic [QUEUE_DEPTH-1:0] mask;
        always_comb begin
            mask = cand;
            sel = '0;
            for (int k = 0; k < ISSUE_WIDTH; k++) begin
                for (int i = 0; i < QUEUE_DEPTH; i++)
                    sel[k][i] = mask[i] && ((mask & ((ONE << i) - ONE)) == '0);
                mask = mask & ~sel[k];
            end
        end
    end
    always_comb begin
        bus.issue_idx = '0;
        bus.issue_valid = '0;
        freed = '0;
        for (int k = 0; k < ISSUE_WIDTH; k++) begin
            bus.issue_valid[k] = |sel[k];
            freed = freed | ((bus.issue_ack[k] && bus.issue_valid[k]) ? sel[k] : '0);
            for (int i = 0; i < QUEUE_DEPTH; i++)
                bus.issue_idx[k*IW +: IW] = bus.issue_idx[k*IW +: IW] | (sel[k][i] ? IW'(i) : '0);
        end
    end
    always_ff @(posedge clk or posedge rst) begin
        if (rst) occ <= '0;
        else occ <= bus.flush ? '0 : ((occ & ~freed) | (bus.alloc_ack ? (ONE << free_idx) : '0));
    end
endmodule
